// File: rtl/sdram_stream_sched.sv
// Burst scheduler for an SDRAM ring buffer. It arbitrates refresh, write and
// read bursts and issues one command at a time under an ack/done handshake.
module sdram_stream_sched #(
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned REF_INTERVAL = 1560
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr,
    input  logic [7:0]            cfg_d,
    input  logic                  wr_rdy,
    input  logic                  rd_rdy,
    input  logic                  cmd_ack,
    input  logic                  burst_done,
    output logic                  cmd_valid,
    output logic [1:0]            cmd_op,
    output logic [DEPTH_LOG2-1:0] cmd_addr,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy,
    output logic                  ref_late
);
    localparam int unsigned        RCW      = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [RCW-1:0]     REF_LAST = RCW'(REF_INTERVAL - 1);
    localparam logic [RCW-1:0]     RC_ONE   = RCW'(1);
    localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0] SLOTS   = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT_DONE} state_t;
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_WRITE   = 2'b01,
        OP_READ    = 2'b10,
        OP_REFRESH = 2'b11
    } op_t;

    state_t                state_q, state_d;
    logic [1:0]            cfg_en_q, cfg_en_d;
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [RCW-1:0]        ref_cnt_q, ref_cnt_d;
    logic                  ref_pend_q, ref_pend_d;
    logic                  ref_late_q, ref_late_d;
    logic                  last_rd_q, last_rd_d;
    op_t                   op_q, op_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;

    logic [DEPTH_LOG2:0] level_w;
    logic                full, empty, wr_elig, rd_elig, ref_tc, ref_clr;
    logic                cfg_unused;

    assign cfg_unused = ^cfg_d[7:2];
    assign level_w    = wr_ptr_q - rd_ptr_q;
    assign full       = (level_w == SLOTS);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign wr_elig    = cfg_en_q[0] & wr_rdy & ~full;
    assign rd_elig    = cfg_en_q[1] & rd_rdy & ~empty;
    assign ref_tc     = (ref_cnt_q == REF_LAST);

    always_comb begin
        state_d    = state_q;
        cfg_en_d   = cfg_en_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ref_cnt_d  = ref_tc ? '0 : ref_cnt_q + RC_ONE;
        ref_pend_d = ref_pend_q;
        ref_late_d = ref_late_q;
        last_rd_d  = last_rd_q;
        op_d       = op_q;
        addr_d     = addr_q;
        ref_clr    = 1'b0;

        if (cfg_wr) cfg_en_d = cfg_d[1:0];

        case (state_q)
            IDLE: begin
                if (ref_pend_q || wr_elig || rd_elig) state_d = ARB;
            end
            ARB: begin
                state_d = ISSUE;
                if (ref_pend_q) begin
                    op_d   = OP_REFRESH;
                    addr_d = '0;
                end else if (wr_elig && (!rd_elig || last_rd_q)) begin
                    op_d      = OP_WRITE;
                    addr_d    = wr_ptr_q[DEPTH_LOG2-1:0];
                    last_rd_d = 1'b0;
                end else if (rd_elig) begin
                    op_d      = OP_READ;
                    addr_d    = rd_ptr_q[DEPTH_LOG2-1:0];
                    last_rd_d = 1'b1;
                end else begin
                    // Requester vanished between IDLE and ARB: retry rather than issue a NOP.
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (cmd_ack) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (burst_done) begin
                    state_d = IDLE;
                    case (op_q)
                        OP_WRITE:   wr_ptr_d = wr_ptr_q + PTR_ONE;
                        OP_READ:    rd_ptr_d = rd_ptr_q + PTR_ONE;
                        OP_REFRESH: ref_clr  = 1'b1;
                        default:    ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        // A terminal count with a refresh still outstanding flags lateness instead of queuing again.
        if (ref_clr) ref_pend_d = 1'b0;
        if (ref_tc) begin
            if (ref_pend_q) ref_late_d = 1'b1;
            else            ref_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_en_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            ref_late_q <= 1'b0;
            last_rd_q  <= 1'b1;
            op_q       <= OP_NOP;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cfg_en_q   <= cfg_en_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            ref_late_q <= ref_late_d;
            last_rd_q  <= last_rd_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
        end
    end

    assign cmd_valid = (state_q == ISSUE);
    assign cmd_op    = cmd_valid ? op_q : OP_NOP;
    assign cmd_addr  = cmd_valid ? addr_q : '0;
    assign level     = level_w;
    assign busy      = (state_q != IDLE);
    assign ref_late  = ref_late_q;

endmodule

// File: tb/tb_sdram_stream_sched.sv
// Bench for sdram_stream_sched: the bench plays the SDRAM core and the stream
// endpoints and predicts every grant from a transaction-level model.
module tb_sdram_stream_sched;
    localparam int D     = 2;
    localparam int N     = 20;
    localparam int SLOTS = 4;

    logic         clk = 1'b0;
    logic         rst, cfg_wr, wr_rdy, rd_rdy, cmd_ack, burst_done;
    logic [7:0]   cfg_d;
    logic         cmd_valid, busy, ref_late;
    logic [1:0]   cmd_op;
    logic [D-1:0] cmd_addr;
    logic [D:0]   level;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bursts written/read as plain counts, config, last granted op (1 W, 2 R).
    int         m_wr, m_rd, m_last, m_cur_op;
    logic [1:0] m_cfg;
    bit         m_in_wait;
    int         m_cnt;
    bit         m_pend, m_late;

    sdram_stream_sched #(.DEPTH_LOG2(D), .REF_INTERVAL(N)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_d(cfg_d),
        .wr_rdy(wr_rdy), .rd_rdy(rd_rdy), .cmd_ack(cmd_ack), .burst_done(burst_done),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .level(level), .busy(busy), .ref_late(ref_late)
    );

    always #5 clk = ~clk;

    // Refresh bookkeeping: a request every N cycles since reset, retired by a finished refresh.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_pend <= 1'b0;
            m_late <= 1'b0;
        end else begin
            m_cnt <= (m_cnt + 1) % N;
            if (m_cnt == N - 1 && m_pend) m_late <= 1'b1;
            if (m_cnt == N - 1 && !m_pend) m_pend <= 1'b1;
            else if (m_in_wait && burst_done && m_cur_op == 3) m_pend <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int lvl;
        bit we, re;
        lvl = m_wr - m_rd;
        if (m_pend) return 3;
        we = m_cfg[0] && wr_rdy && (lvl < SLOTS);
        re = m_cfg[1] && rd_rdy && (lvl > 0);
        if (we && re) return (m_last == 2) ? 1 : 2;
        if (we) return 1;
        if (re) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_last = 2; m_cfg = 2'b00;
        m_in_wait = 1'b0; m_cur_op = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_wr = 1'b0; cfg_d = 8'h00; wr_rdy = 1'b0; rd_rdy = 1'b0;
        cmd_ack = 1'b0; burst_done = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_op", cmd_op, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_late", ref_late, 0);
        rst = 1'b0;
    endtask

    // Only used right after reset: nothing is pending and the old config enables nothing.
    task automatic cfg_idle(input int val);
        cfg_wr = 1'b1; cfg_d = val[7:0];
        chk("cfgw_busy", busy, 0);
        @(negedge clk);
        cfg_wr = 1'b0; m_cfg = val[1:0];
        chk("cfgw_old_cfg_used", busy, 0);
    endtask

    // Starts at the negedge of a cycle in which the DUT is IDLE; ends the same way.
    task automatic run_txn(output int op, output int addr, input bit wr_r, input bit rd_r,
                           input int cfg_new, input int ack_dly, input int done_dly,
                           input bit cfg_wo, input bit stall_ref, input bit spur,
                           input bit rst_issue);
        int waited, exp_addr, adly;
        wr_rdy = wr_r; rd_rdy = rd_r;
        waited = 0;
        op = 0; addr = 0;
        while (pick() == 0) begin
            chk("idle_valid", cmd_valid, 0);
            chk("idle_busy", busy, 0);
            @(negedge clk);
            waited++;
            n_tests++;
            assert (waited <= 3 * N) else begin
                n_fail++;
                $error("FAIL idle_bound: waited %0d cycles, limit %0d", waited, 3 * N);
                return;
            end
        end
        chk("c0_valid", cmd_valid, 0);
        chk("c0_busy", busy, 0);
        @(negedge clk);
        chk("arb_busy", busy, 1);
        chk("arb_valid", cmd_valid, 0);
        op = pick();
        exp_addr = (op == 1) ? m_wr % SLOTS : (op == 2) ? m_rd % SLOTS : 0;
        if (op == 1 || op == 2) m_last = op;
        m_cur_op = op;
        @(negedge clk);
        chk("issue_valid", cmd_valid, 1);
        chk("issue_op", cmd_op, op);
        chk("issue_addr", cmd_addr, exp_addr);
        chk("issue_level", level, m_wr - m_rd);
        addr = int'(cmd_addr);
        if (rst_issue) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            chk("rstmid_valid", cmd_valid, 0);
            chk("rstmid_level", level, 0);
            chk("rstmid_busy", busy, 0);
            @(negedge clk);
            chk("rstpost_valid", cmd_valid, 0);
            chk("rstpost_op", cmd_op, 0);
            chk("rstpost_addr", cmd_addr, 0);
            chk("rstpost_busy", busy, 0);
            chk("rstpost_late", ref_late, 0);
            return;
        end
        adly = (stall_ref && op == 3) ? 25 : ack_dly;
        for (int i = 0; i < adly; i++) begin
            if (spur) burst_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            burst_done = 1'b0;
            chk("hold_valid", cmd_valid, 1);
            chk("hold_op", cmd_op, op);
            chk("hold_addr", cmd_addr, exp_addr);
        end
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        m_in_wait = 1'b1;
        chk("wait_valid", cmd_valid, 0);
        chk("wait_op", cmd_op, 0);
        chk("wait_busy", busy, 1);
        if (cfg_new >= 0 && (!cfg_wo || op == 1)) begin
            cfg_wr = 1'b1; cfg_d = cfg_new[7:0];
            @(negedge clk);
            cfg_wr = 1'b0; m_cfg = cfg_new[1:0];
            chk("wait_cfg_busy", busy, 1);
        end
        for (int i = 0; i < done_dly; i++) begin
            @(negedge clk);
            chk("wait2_valid", cmd_valid, 0);
            chk("wait2_busy", busy, 1);
        end
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        m_in_wait = 1'b0;
        if (op == 1) m_wr++;
        if (op == 2) m_rd++;
        chk("done_level", level, m_wr - m_rd);
        chk("done_busy", busy, 0);
        chk("done_valid", cmd_valid, 0);
        chk("done_late", ref_late, m_late);
    endtask

    task automatic do_ops(input int want, input int cnt, input bit wr_r, input bit rd_r,
                          input int cfg_new, input string tag);
        int op, a, got;
        got = 0;
        for (int k = 0; k < 4 * cnt + 8 && got < cnt; k++) begin
            run_txn(op, a, wr_r, rd_r, cfg_new, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
            if (op == want) got++;
        end
        chk(tag, got, cnt);
    endtask

    int op, a, nw, nr, exp_op, got, lvl0, cn;

    initial begin
        do_reset();
        cfg_idle(8'h01);

        // Basic writes fill the 4-slot ring with addresses 0..3.
        nw = 0;
        for (int k = 0; k < 16 && nw < 4; k++) begin
            run_txn(op, a, 1'b1, 1'b0, -1, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
            if (op == 1) begin
                chk("basic_addr", a, nw);
                nw++;
                chk("basic_level", level, nw);
            end
        end
        chk("basic_count", nw, 4);

        // Full: only refresh may be granted; switch to read-only during it.
        run_txn(op, a, 1'b1, 1'b0, 8'h02, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_refresh_only", op, 3);
        chk("full_level", level, 4);

        nr = 0;
        for (int k = 0; k < 16 && nr < 4; k++) begin
            run_txn(op, a, 1'b1, 1'b1, -1, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
            if (op == 2) begin
                chk("drain_addr", a, nr);
                nr++;
                chk("drain_level", level, 4 - nr);
            end
        end
        chk("drain_count", nr, 4);

        run_txn(op, a, 1'b1, 1'b1, 8'hFD, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("empty_refresh_only", op, 3);
        chk("empty_level", level, 0);

        // Fifth write wraps back to slot 0.
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            run_txn(op, a, 1'b1, 1'b0, -1, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
            if (op == 1) begin
                got = 1;
                chk("wrap_addr", a, 0);
            end
        end
        chk("wrap_seen", got, 1);

        // Round robin from level 2 with READ granted last: W, R, W, R.
        do_ops(1, 2, 1'b1, 1'b0, 8'h03, "rr_prefill");
        do_ops(2, 1, 1'b0, 1'b1, -1, "rr_setup_read");
        exp_op = 1; got = 0;
        for (int k = 0; k < 12 && got < 4; k++) begin
            run_txn(op, a, 1'b1, 1'b1, -1, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
            if (op != 3) begin
                chk("rr_seq", op, exp_op);
                chk("rr_level_range", (level >= 2 && level <= 3), 1'b1);
                exp_op = (exp_op == 1) ? 2 : 1;
                got++;
            end
        end
        chk("rr_count", got, 4);

        // Randomised traffic, handshake timing, config and stray done pulses.
        for (int k = 0; k < 40; k++) begin
            cn = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) : -1;
            run_txn(op, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cn,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Stall a refresh past the next interval: lateness is flagged and sticks.
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            run_txn(op, a, 1'b1, 1'b0, (k == 0) ? 1 : -1, 1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
            if (op == 3) got = 1;
        end
        chk("stall_seen", got, 1);
        chk("ref_late_set", ref_late, 1);
        for (int k = 0; k < 3; k++)
            run_txn(op, a, 1'b1, 1'b1, 3, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ref_late_sticky", ref_late, 1);

        // Disable mid-write: the write still retires, then only refreshes follow.
        got = 0;
        for (int k = 0; k < 12 && got == 0; k++) begin
            lvl0 = m_wr - m_rd;
            run_txn(op, a, 1'b1, 1'b1, 0, 1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
            if (op == 1) begin
                got = 1;
                chk("disable_write_retired", level, lvl0 + 1);
            end
        end
        chk("disable_seen", got, 1);
        for (int k = 0; k < 3; k++) begin
            run_txn(op, a, 1'b1, 1'b1, -1, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("only_refresh", op, 3);
        end

        // Reset in ISSUE abandons the command; operation resumes from slot 0.
        run_txn(op, a, 1'b1, 1'b1, -1, 1, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        cfg_idle(8'h01);
        run_txn(op, a, 1'b1, 1'b0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_op", op, 1);
        chk("resume_addr", a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
